// File: rtl/router_term_tx_if.sv
// Host-write and router-handshake bundle for one terminal transmit agent.
// The slave modport is the agent itself; master is the host/router side.
interface router_term_tx_if #(
  parameter int PCK_SZ = 40,
  parameter int DEPTH  = 16
);
  localparam int PLD_W = PCK_SZ - 28;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [5:0]        wr_dst;
  logic [PLD_W-1:0]  wr_pld;
  logic              wr_full;
  logic [PCK_SZ-1:0] data_out_i_in;
  logic              pndng_i_in;
  logic              popin;
  logic [15:0]       tx_cnt;
  logic [LVL_W-1:0]  level;
  logic              err_ovf;
  logic              err_dst;
  logic              err_udf;
  logic              stall;
  logic              err_clr;

  modport master (
    output wr_en, wr_dst, wr_pld, popin, err_clr,
    input  wr_full, data_out_i_in, pndng_i_in, tx_cnt, level,
           err_ovf, err_dst, err_udf, stall
  );

  modport slave (
    input  wr_en, wr_dst, wr_pld, popin, err_clr,
    output wr_full, data_out_i_in, pndng_i_in, tx_cnt, level,
           err_ovf, err_dst, err_udf, stall
  );
endinterface

// File: rtl/router_term_tx.sv
// Terminal transmit agent: assembles router packets from host writes, queues
// them in a first-word-fall-through FIFO and tracks drops and router starvation.
module router_term_tx #(
  parameter int ROWS    = 4,
  parameter int COLUMS  = 4,
  parameter int PCK_SZ  = 40,
  parameter int DEPTH   = 16,
  parameter int TERM_ID = 0,
  parameter int TIMEOUT = 128
) (
  input  logic             clk,
  input  logic             reset,
  router_term_tx_if.slave  bus
);
  localparam int N_TERMS = 2 * ROWS + 2 * COLUMS;
  localparam int DST_MSB = PCK_SZ - 9;
  localparam int DST_LSB = PCK_SZ - 14;
  localparam int PLD_W   = PCK_SZ - 28;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam int WD_W    = $clog2(TIMEOUT + 1);

  localparam logic [6:0]       N_TERMS_L = 7'(N_TERMS);
  localparam logic [LVL_W-1:0] DEPTH_L   = LVL_W'(DEPTH);
  localparam logic [WD_W-1:0]  TIMEOUT_L = WD_W'(TIMEOUT);

  logic [PCK_SZ-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [7:0]        seq_q, seq_d;
  logic [15:0]       tx_cnt_q, tx_cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              ovf_q, ovf_d, dst_q, dst_d, udf_q, udf_d, stall_q, stall_d;

  logic              full, pending, dst_ok, wr_ok, pop_ok;
  logic [PCK_SZ-1:0] wr_pkt;

  // Full and pending come from registered occupancy, so a same-cycle pop
  // never frees room for a write arriving in that cycle.
  assign full    = (level_q == DEPTH_L);
  assign pending = (level_q != '0);
  assign dst_ok  = ({1'b0, bus.wr_dst} < N_TERMS_L);
  assign wr_ok   = bus.wr_en & ~full & dst_ok;
  assign pop_ok  = bus.popin & pending;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_pkt                       = '0;
    wr_pkt[DST_MSB:DST_LSB]      = bus.wr_dst;
    wr_pkt[PCK_SZ-15 -: 6]       = 6'(TERM_ID);
    wr_pkt[PCK_SZ-21 -: 8]       = seq_q;
    wr_pkt[PLD_W-1:0]            = bus.wr_pld;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    seq_d    = seq_q;
    tx_cnt_d = tx_cnt_q;
    wd_d     = wd_q;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      seq_d    = seq_q + 8'd1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      tx_cnt_d = tx_cnt_q + 16'd1;
    end
    case ({wr_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Watchdog counts cycles the head sits unconsumed and saturates at TIMEOUT.
    if (!pending || bus.popin) wd_d = '0;
    else if (wd_q != TIMEOUT_L) wd_d = wd_q + 1'b1;

    // Sticky flags: a new event in the same cycle as err_clr wins.
    ovf_d   = (ovf_q   & ~bus.err_clr) | (bus.wr_en & dst_ok & full);
    dst_d   = (dst_q   & ~bus.err_clr) | (bus.wr_en & ~dst_ok);
    udf_d   = (udf_q   & ~bus.err_clr) | (bus.popin & ~pending);
    stall_d = (stall_q & ~bus.err_clr) | (wd_d == TIMEOUT_L);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      seq_q    <= '0;
      tx_cnt_q <= '0;
      wd_q     <= '0;
      ovf_q    <= 1'b0;
      dst_q    <= 1'b0;
      udf_q    <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      seq_q    <= seq_d;
      tx_cnt_q <= tx_cnt_d;
      wd_q     <= wd_d;
      ovf_q    <= ovf_d;
      dst_q    <= dst_d;
      udf_q    <= udf_d;
      stall_q  <= stall_d;
    end
  end

  // NOTE: the storage array has no reset; the empty-gating on the output hides stale entries.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_pkt;
  end

  assign bus.wr_full       = full;
  assign bus.pndng_i_in    = pending;
  assign bus.data_out_i_in = pending ? mem_q[rd_ptr_q] : '0;
  assign bus.level         = level_q;
  assign bus.tx_cnt        = tx_cnt_q;
  assign bus.err_ovf       = ovf_q;
  assign bus.err_dst       = dst_q;
  assign bus.err_udf       = udf_q;
  assign bus.stall         = stall_q;
endmodule

// File: tb/tb_router_term_tx.sv
// Directed-plus-random bench for router_term_tx against a queue-based
// packet model derived from the terminal's acceptance and handshake rules.
module tb_router_term_tx;
  localparam int ROWS    = 4;
  localparam int COLUMS  = 4;
  localparam int PCK_SZ  = 40;
  localparam int DEPTH   = 16;
  localparam int TERM_ID = 0;
  localparam int TIMEOUT = 128;
  localparam int N_TERMS = 2 * ROWS + 2 * COLUMS;
  localparam int PLD_W   = PCK_SZ - 28;

  logic clk = 1'b0;
  logic reset;

  router_term_tx_if #(.PCK_SZ(PCK_SZ), .DEPTH(DEPTH)) bus ();

  router_term_tx #(
    .ROWS(ROWS), .COLUMS(COLUMS), .PCK_SZ(PCK_SZ),
    .DEPTH(DEPTH), .TERM_ID(TERM_ID), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [PCK_SZ-1:0] m_q[$];
  logic [7:0]        m_seq;
  int                m_tx;
  int                m_wait;
  bit                m_ovf, m_dst, m_udf, m_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PCK_SZ-1:0] mk_pkt(input logic [5:0] dst, input logic [7:0] seq,
                                               input logic [PLD_W-1:0] pld);
    logic [5:0] src;
    src = 6'(TERM_ID);
    return {8'h00, dst, src, seq, pld};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_seq = 8'd0; m_tx = 0; m_wait = 0;
    m_ovf = 0; m_dst = 0; m_udf = 0; m_stall = 0;
  endtask

  task automatic model_step(input bit wen, input logic [5:0] dst, input logic [PLD_W-1:0] pld,
                            input bit pop, input bit clr);
    bit pend, full, good;
    pend = (m_q.size() != 0);
    full = (m_q.size() == DEPTH);
    good = (int'(dst) < N_TERMS);
    if (pop && pend) begin
      void'(m_q.pop_front());
      m_tx++;
    end
    if (wen && good && !full) begin
      m_q.push_back(mk_pkt(dst, m_seq, pld));
      m_seq++;
    end
    if (pend && !pop) m_wait = (m_wait + 1 > TIMEOUT) ? TIMEOUT : m_wait + 1;
    else m_wait = 0;
    m_ovf   = (m_ovf   && !clr) || (wen && good && full);
    m_dst   = (m_dst   && !clr) || (wen && !good);
    m_udf   = (m_udf   && !clr) || (pop && !pend);
    m_stall = (m_stall && !clr) || (m_wait >= TIMEOUT);
  endtask

  task automatic check_all(input string tag);
    logic [PCK_SZ-1:0] head;
    head = (m_q.size() != 0) ? m_q[0] : '0;
    check({tag, ".pndng"}, 64'(bus.pndng_i_in), 64'(m_q.size() != 0));
    check({tag, ".data"},  64'(bus.data_out_i_in), 64'(head));
    check({tag, ".level"}, 64'(bus.level), 64'(m_q.size()));
    check({tag, ".full"},  64'(bus.wr_full), 64'(m_q.size() == DEPTH));
    check({tag, ".tx"},    64'(bus.tx_cnt), 64'(m_tx % 65536));
    check({tag, ".ovf"},   64'(bus.err_ovf), 64'(m_ovf));
    check({tag, ".dst"},   64'(bus.err_dst), 64'(m_dst));
    check({tag, ".udf"},   64'(bus.err_udf), 64'(m_udf));
    check({tag, ".stall"}, 64'(bus.stall), 64'(m_stall));
  endtask

  // Called at a negedge: drive, let one rising edge pass, compare at the next negedge.
  task automatic cycle(input string tag, input bit wen, input logic [5:0] dst,
                       input logic [PLD_W-1:0] pld, input bit pop, input bit clr);
    bus.wr_en = wen; bus.wr_dst = dst; bus.wr_pld = pld;
    bus.popin = pop; bus.err_clr = clr;
    @(posedge clk);
    model_step(wen, dst, pld, pop, clr);
    @(negedge clk);
    bus.wr_en = 1'b0; bus.popin = 1'b0; bus.err_clr = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_dst = '0; bus.wr_pld = '0;
    bus.popin = 1'b0; bus.err_clr = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_all(tag);
  endtask

  function automatic logic [5:0] rnd_dst();
    return 6'($urandom_range(N_TERMS - 1, 0));
  endfunction

  function automatic logic [PLD_W-1:0] rnd_pld();
    return PLD_W'($urandom);
  endfunction

  initial begin
    logic [PCK_SZ-1:0] pkt;
    logic [7:0]        exp_seq;

    // Scenario 1: single packet latency and layout
    @(negedge clk);
    do_reset("rst0");
    cycle("wr1", 1, 6'd5, 12'hABC, 0, 0);
    check("layout", 64'(bus.data_out_i_in), 64'(40'h00_1400_0ABC));
    cycle("pop1", 0, 6'd0, 12'h000, 1, 0);
    check("pop1.tx_is_1", 64'(bus.tx_cnt), 64'd1);

    // Scenario 2: fill, overflow with simultaneous pop, seq continuity
    do_reset("rst1");
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1, rnd_dst(), rnd_pld(), 0, 0);
    check("fill.level16", 64'(bus.level), 64'd16);
    check("fill.full", 64'(bus.wr_full), 64'd1);
    cycle("ovf", 1, rnd_dst(), rnd_pld(), 1, 0);
    check("ovf.flag", 64'(bus.err_ovf), 64'd1);
    check("ovf.level15", 64'(bus.level), 64'd15);
    cycle("after_ovf", 1, rnd_dst(), rnd_pld(), 0, 0);
    while (m_q.size() > 1) cycle("drain", 0, 6'd0, '0, 1, 0);
    pkt = bus.data_out_i_in;
    check("ovf.next_seq16", 64'(pkt[PCK_SZ-21 -: 8]), 64'd16);

    // Scenario 3: bad destination leaves seq and level untouched
    do_reset("rst2");
    cycle("baddst", 1, 6'd16, 12'h123, 0, 0);
    check("baddst.flag", 64'(bus.err_dst), 64'd1);
    check("baddst.ovf0", 64'(bus.err_ovf), 64'd0);
    check("baddst.level0", 64'(bus.level), 64'd0);
    cycle("gooddst", 1, 6'd15, 12'h456, 0, 0);
    pkt = bus.data_out_i_in;
    check("gooddst.seq0", 64'(pkt[PCK_SZ-21 -: 8]), 64'd0);
    cycle("clr_dst", 0, 6'd0, '0, 0, 1);
    check("clr_dst.flag0", 64'(bus.err_dst), 64'd0);
    cycle("clr_vs_set", 1, 6'd40, 12'h000, 0, 1);
    check("set_wins", 64'(bus.err_dst), 64'd1);

    // Scenario 4: watchdog fires after exactly TIMEOUT idle cycles
    do_reset("rst3");
    cycle("wd_wr", 1, 6'd3, 12'h777, 0, 0);
    for (int n = 1; n <= TIMEOUT + 3; n++) begin
      cycle("wd_hold", 0, 6'd0, '0, 0, 0);
      check("wd.stall_edge", 64'(bus.stall), 64'(n >= TIMEOUT));
    end
    cycle("wd_pop", 0, 6'd0, '0, 1, 0);
    check("wd.stall_sticky", 64'(bus.stall), 64'd1);
    cycle("wd_clr", 0, 6'd0, '0, 0, 1);
    check("wd.stall_clr", 64'(bus.stall), 64'd0);

    // Scenario 5: steady stream with level 4 and in-order seq wrap
    do_reset("rst4");
    for (int i = 0; i < 4; i++) cycle("pre4", 1, rnd_dst(), rnd_pld(), 0, 0);
    exp_seq = 8'd0;
    for (int i = 0; i < 300; i++) begin
      pkt = bus.data_out_i_in;
      check("stream.seq", 64'(pkt[PCK_SZ-21 -: 8]), 64'(exp_seq));
      exp_seq++;
      cycle("stream", 1, rnd_dst(), rnd_pld(), 1, 0);
      check("stream.level4", 64'(bus.level), 64'd4);
    end
    check("stream.tx300", 64'(bus.tx_cnt), 64'd300);

    // Scenario 6: underflow, write+pop into empty, reset mid-operation
    do_reset("rst5");
    cycle("udf", 0, 6'd0, '0, 1, 0);
    check("udf.flag", 64'(bus.err_udf), 64'd1);
    check("udf.tx0", 64'(bus.tx_cnt), 64'd0);
    cycle("wr_pop_empty", 1, 6'd7, 12'h0F0, 1, 0);
    check("wr_pop_empty.pndng", 64'(bus.pndng_i_in), 64'd1);
    for (int i = 0; i < 7; i++) cycle("q8", 1, rnd_dst(), rnd_pld(), 0, 0);
    check("q8.level", 64'(bus.level), 64'd8);
    do_reset("rst_mid");
    check("rst_mid.pndng0", 64'(bus.pndng_i_in), 64'd0);
    check("rst_mid.udf0", 64'(bus.err_udf), 64'd0);

    // Scenario 7: random traffic against the model
    do_reset("rst6");
    for (int i = 0; i < 600; i++) begin
      cycle("rand", ($urandom_range(3, 0) != 0), 6'($urandom_range(N_TERMS + 1, 0)),
            rnd_pld(), ($urandom_range(2, 0) == 0), ($urandom_range(15, 0) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/router_term_tx.md
Name: router_term_tx

Overview:
- Terminal-side transmit agent for one router terminal. It is the source end of the terminal input handshake (data_out_i_in / pndng_i_in / popin).
- A host writes destination + payload. The block assembles full router packets, queues them in a FIFO and presents the head to the router with first-word fall-through.
- The router consumes the head by pulsing popin. The block also tracks sent count, drops and router starvation.

Parameters:
- ROWS, 4, mesh rows
- COLUMS, 4, mesh columns
- PCK_SZ, 40, packet width in bits
- DEPTH, 16, FIFO entries (power of two, >=2)
- TERM_ID, 0, this terminal's index (0..N_TERMS-1), inserted as source
- TIMEOUT, 128, cycles of pndng_i_in without popin before stall is flagged

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- wr_en  in  1  host write strobe
- wr_dst  in  6  destination terminal index
- wr_pld  in  PLD_W  payload, where PLD_W = PCK_SZ-28 (12 at default)
- wr_full  out  1  FIFO full
- data_out_i_in  out  PCK_SZ  head packet presented to router
- pndng_i_in  out  1  head valid (FIFO non-empty)
- popin  in  1  router consumes head this cycle
- tx_cnt  out  16  packets popped by router, wraps at 2^16
- level  out  $clog2(DEPTH)+1  current occupancy
- err_ovf  out  1  sticky: write dropped because FIFO full
- err_dst  out  1  sticky: write dropped because wr_dst >= N_TERMS
- err_udf  out  1  sticky: popin while pndng_i_in=0
- stall  out  1  sticky: head waited TIMEOUT cycles
- err_clr  in  1  clears all sticky flags

Behaviour:
- N_TERMS = 2*ROWS+2*COLUMS. Package constants are DST_MSB=PCK_SZ-9 and DST_LSB=PCK_SZ-14.
- Packet layout, MSB down:
  - [PCK_SZ-1:PCK_SZ-8] next-jump = 0
  - [DST_MSB:DST_LSB] = wr_dst
  - [PCK_SZ-15:PCK_SZ-20] = TERM_ID
  - [PCK_SZ-21:PCK_SZ-28] = seq (8-bit, wraps 255->0)
  - [PCK_SZ-29:0] = wr_pld
- Reset (synchronous, all state):
  - FIFO pointers 0; level=0; pndng_i_in=0; data_out_i_in=0.
  - tx_cnt=0, seq=0, watchdog=0, all sticky flags 0, wr_full=0.
  - Reset mid-operation discards all queued packets. pndng_i_in is 0 in the cycle after reset is sampled.
- Write acceptance:
  - A write is accepted iff wr_en & ~wr_full & (wr_dst < N_TERMS).
  - An accepted write stores the packet with the current seq, then seq increments.
  - Full is evaluated before same-cycle pop, so a write while full is rejected even if popin=1. Rejected writes set err_ovf.
  - Bad destination has priority over full: a write with wr_dst >= N_TERMS sets err_dst only. The packet is dropped and seq is not incremented.
- Output handshake:
  - pndng_i_in = (level != 0), registered.
  - data_out_i_in always equals the head entry while pndng_i_in=1, and 0 when empty.
  - popin with pndng_i_in=1 removes the head; the next entry is visible the following cycle. tx_cnt increments.
  - popin with pndng_i_in=0 is ignored; it sets err_udf.
  - Data and pndng are stable while not popped.
- Latency:
  - A write accepted in cycle t into an empty FIFO gives pndng_i_in=1 and valid data in cycle t+1.
  - A write into an empty FIFO together with popin: the pop is ignored (err_udf set) and the write is accepted.
- Simultaneous write and pop (non-full, non-empty): level is unchanged and both pointers advance.
- Pointer behaviour:
  - Pointers wrap at DEPTH.
  - wr_full = (level == DEPTH).
  - Back-to-back pops on every cycle drain one entry per cycle.
- Watchdog:
  - The counter increments each cycle pndng_i_in=1 & popin=0. It clears on popin or when empty.
  - On reaching TIMEOUT, stall is set and the counter saturates.
- Sticky flags:
  - Cleared by err_clr.
  - If err_clr coincides with a new error event, the flag stays 1 (set wins).

Test Plan:
- Reset, then write dst=5, pld=0xABC -> next cycle pndng_i_in=1; data_out_i_in = {8'h00, 6'd5, 6'd0, 8'd0, 12'hABC}; popin 1 cycle -> pndng_i_in=0, tx_cnt=1.
- 16 writes without pop -> wr_full=1, level=16; 17th write plus simultaneous popin -> write dropped, err_ovf=1, level=15; seq in the next accepted packet = 16.
- Write dst=16 (N_TERMS=16) -> err_dst=1, level unchanged, next valid write carries seq unchanged; err_clr -> err_dst=0.
- Hold one packet 128 cycles with popin=0 -> stall=1 in cycle 128, never before; popin -> counter clears, stall remains until err_clr.
- Fill 4 packets, then write+pop every cycle for 300 cycles -> level stays 4, packets exit in order with contiguous seq wrapping 255->0, tx_cnt=300.
- popin while empty -> err_udf=1, tx_cnt unchanged; reset asserted with 8 queued -> next cycle pndng_i_in=0, level=0, flags 0.
